// File: rtl/dff_skid_slice.sv
// Two-entry registered valid/ready pipeline slice (main + skid register).
// Every output is driven directly by a flop, so both handshake directions are cut.
module dff_skid_slice #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  flush,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [1:0]            count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t                state, state_nxt;
  logic [DATA_WIDTH-1:0] main_q, main_nxt;
  logic [DATA_WIDTH-1:0] skid_q, skid_nxt;
  logic                  m_valid_nxt, s_ready_nxt;
  logic                  in_xfer, out_xfer;

  assign in_xfer  = s_valid & s_ready;
  assign out_xfer = m_valid & m_ready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      m_valid <= 1'b0;
      s_ready <= 1'b1;
    end else begin
      state   <= state_nxt;
      main_q  <= main_nxt;
      skid_q  <= skid_nxt;
      m_valid <= m_valid_nxt;
      s_ready <= s_ready_nxt;
    end
  end

  // Handshake flags are computed from the next state so they stay registered.
  always_comb begin
    state_nxt = state;
    main_nxt  = main_q;
    skid_nxt  = skid_q;
    if (flush) begin
      state_nxt = EMPTY;
      main_nxt  = '0;
      skid_nxt  = '0;
    end else begin
      case (state)
        EMPTY: begin
          if (in_xfer) begin
            main_nxt  = s_data;
            state_nxt = ONE;
          end
        end
        ONE: begin
          if (in_xfer && out_xfer) begin
            main_nxt = s_data;
          end else if (in_xfer) begin
            skid_nxt  = s_data;
            state_nxt = FULL;
          end else if (out_xfer) begin
            state_nxt = EMPTY;
          end
        end
        FULL: begin
          if (out_xfer) begin
            main_nxt  = skid_q;
            state_nxt = ONE;
          end
        end
        default: state_nxt = EMPTY;
      endcase
    end
    m_valid_nxt = (state_nxt != EMPTY);
    s_ready_nxt = (state_nxt != FULL);
  end

  assign m_data = main_q;
  assign count  = state;

endmodule

// File: tb/tb_dff_skid_slice.sv
// Directed bench for dff_skid_slice with a scoreboard queue that checks
// ordering of every beat leaving the slice, plus per-cycle state checks.
module tb_dff_skid_slice;

  logic        clk;
  logic        rstn;
  logic        flush;
  logic        s_valid;
  logic        s_ready;
  logic [15:0] s_data;
  logic        m_valid;
  logic        m_ready;
  logic [15:0] m_data;
  logic [1:0]  count;

  int          total;
  int          bad;
  int          popped;
  logic [15:0] exp_q[$];

  dff_skid_slice #(.DATA_WIDTH(16)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .flush   (flush),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .count   (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs at the falling edge, then wait past the rising edge.
  task automatic applyStimulus(input logic sv, input logic [15:0] sd,
                               input logic mr, input logic fl);
    @(negedge clk);
    s_valid = sv;
    s_data  = sd;
    m_ready = mr;
    flush   = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic emv, input logic esr,
                             input logic [1:0] ecnt, input logic [15:0] edata,
                             input logic cdata);
    total++;
    if (m_valid !== emv || s_ready !== esr || count !== ecnt ||
        (cdata && m_data !== edata)) begin
      bad++;
      $display("[TB] FAIL %s: got mv=%0b sr=%0b cnt=%0d data=%h, want mv=%0b sr=%0b cnt=%0d data=%h",
               name, m_valid, s_ready, count, m_data, emv, esr, ecnt, edata);
    end
  endtask

  // Monitor: samples mid-cycle, once inputs for the coming edge are settled.
  always begin
    @(negedge clk);
    #1;
    if (rstn) begin
      if (flush) begin
        exp_q.delete();
      end else begin
        if (m_valid && m_ready) begin
          total++;
          popped++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("[TB] FAIL unexpected_beat: got data=%h, want no beat", m_data);
          end else begin
            logic [15:0] want;
            want = exp_q.pop_front();
            if (m_data !== want) begin
              bad++;
              $display("[TB] FAIL beat_order: got data=%h, want data=%h", m_data, want);
            end
          end
        end
        if (s_valid && s_ready) exp_q.push_back(s_data);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    total   = 0;
    bad     = 0;
    popped  = 0;
    rstn    = 1'b0;
    flush   = 1'b0;
    s_valid = 1'b0;
    s_data  = 16'h0000;
    m_ready = 1'b0;

    repeat (3) @(negedge clk);
    checkOutput("in_reset", 1'b0, 1'b1, 2'd0, 16'h0000, 1'b1);
    rstn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0);
      checkOutput("idle", 1'b0, 1'b1, 2'd0, 16'h0000, 1'b1);
    end

    for (int i = 1; i <= 16; i++) begin
      applyStimulus(1'b1, 16'(i), 1'b1, 1'b0);
      checkOutput("stream", 1'b1, 1'b1, 2'd1, 16'(i), 1'b1);
    end
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
    checkOutput("stream_end", 1'b0, 1'b1, 2'd0, 16'h0000, 1'b0);

    applyStimulus(1'b1, 16'hAAAA, 1'b0, 1'b0);
    checkOutput("fill_one", 1'b1, 1'b1, 2'd1, 16'hAAAA, 1'b1);
    applyStimulus(1'b1, 16'hBBBB, 1'b0, 1'b0);
    checkOutput("fill_full", 1'b1, 1'b0, 2'd2, 16'hAAAA, 1'b1);
    applyStimulus(1'b1, 16'hCCCC, 1'b0, 1'b0);
    checkOutput("full_hold", 1'b1, 1'b0, 2'd2, 16'hAAAA, 1'b1);

    applyStimulus(1'b1, 16'hCCCC, 1'b1, 1'b0);
    checkOutput("drain_1", 1'b1, 1'b1, 2'd1, 16'hBBBB, 1'b1);
    applyStimulus(1'b1, 16'hCCCC, 1'b1, 1'b0);
    checkOutput("drain_2", 1'b1, 1'b1, 2'd1, 16'hCCCC, 1'b1);
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
    checkOutput("drain_3", 1'b0, 1'b1, 2'd0, 16'h0000, 1'b0);

    applyStimulus(1'b1, 16'h1111, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h2222, 1'b0, 1'b0);
    checkOutput("pre_flush", 1'b1, 1'b0, 2'd2, 16'h1111, 1'b1);
    applyStimulus(1'b1, 16'h1234, 1'b1, 1'b1);
    checkOutput("flush", 1'b0, 1'b1, 2'd0, 16'h0000, 1'b1);
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
    checkOutput("post_flush", 1'b0, 1'b1, 2'd0, 16'h0000, 1'b1);

    applyStimulus(1'b1, 16'h6666, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h7777, 1'b0, 1'b0);
    checkOutput("pre_reset", 1'b1, 1'b0, 2'd2, 16'h6666, 1'b1);
    @(negedge clk);
    s_valid = 1'b0;
    #2;
    rstn = 1'b0;
    exp_q.delete();
    #1;
    checkOutput("async_reset", 1'b0, 1'b1, 2'd0, 16'h0000, 1'b1);
    @(negedge clk);
    rstn = 1'b1;
    applyStimulus(1'b1, 16'h5555, 1'b1, 1'b0);
    checkOutput("after_reset", 1'b1, 1'b1, 2'd1, 16'h5555, 1'b1);
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
    checkOutput("final_empty", 1'b0, 1'b1, 2'd0, 16'h0000, 1'b0);

    repeat (2) @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("[TB] FAIL leftover_beats: got %0d queued, want 0", exp_q.size());
    end
    total++;
    if (popped != 20) begin
      bad++;
      $display("[TB] FAIL beats_out: got %0d, want 20", popped);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dff_skid_slice.md
Name: dff_skid_slice

Overview:
- Two-entry registered pipeline slice. It carries a valid/ready handshake between a producer (s_*) and a consumer (m_*).
- Adds the consumer-side read handshake to the team's load-enabled register style. All outputs come straight from flops, so the slice breaks the timing paths on both the forward data/valid path and the backward ready path.
- Inserted between pipeline stages wherever a stage needs backpressure at full throughput.

Parameters:
- DATA_WIDTH, 16, payload width in bits

Ports:
- clk  input  1  clock, all state updates on rising edge
- rstn  input  1  reset, asynchronous, active-low
- flush  input  1  synchronous clear of all buffered beats
- s_valid  input  1  producer has a beat on s_data
- s_ready  output  1  slice can accept a beat this cycle (registered)
- s_data  input  DATA_WIDTH  producer payload
- m_valid  output  1  m_data holds a valid beat (registered)
- m_ready  input  1  consumer accepts m_data this cycle
- m_data  output  DATA_WIDTH  output payload (registered)
- count  output  2  number of buffered beats, 0..2

Behaviour:
- Reset (rstn low, asynchronous, takes effect immediately):
  - m_valid=0, s_ready=1, m_data=0, count=0.
  - Skid register=0.
  - State=EMPTY.
- Transfers:
  - Input transfer = s_valid & s_ready at a rising edge.
  - Output transfer = m_valid & m_ready at a rising edge.
- State is encoded by count; count is a flop, not derived combinationally. States:
  - EMPTY (count 0): m_valid=0, s_ready=1.
  - ONE (count 1): m_valid=1, s_ready=1, beat in main register.
  - FULL (count 2): m_valid=1, s_ready=0, older beat in main, newer beat in skid.
- Transitions, evaluated at each rising edge when flush=0:
  - EMPTY, input transfer: main<=s_data, go to ONE. Without an input transfer, stay in EMPTY; m_ready is ignored.
  - ONE, input and output transfer: main<=s_data, stay in ONE. This is full throughput, one beat per cycle.
  - ONE, input transfer only: skid<=s_data, go to FULL, s_ready falls.
  - ONE, output transfer only: go to EMPTY, m_valid falls.
  - ONE, neither: hold.
  - FULL, output transfer: main<=skid, go to ONE, s_ready rises.
  - FULL, no output transfer: hold. s_valid is ignored because s_ready=0.
- Latency:
  - A beat accepted into EMPTY, or into ONE together with an output transfer, is visible on m_data after the same edge (one-cycle latency).
  - A beat parked in skid appears one cycle after the consumer drains main.
- Ordering: strict FIFO. No beat is dropped or duplicated outside of flush.
- Stability: while m_valid=1 and m_ready=0, m_data and m_valid are held unchanged.
- Data registers load only on the transitions listed above; otherwise they hold. Their contents are don't-care while the corresponding entry is invalid.
- No combinational path from any input to any output.
- flush=1 at a rising edge:
  - count=0, m_valid=0, s_ready=1, main and skid cleared to 0.
  - flush has priority over every transfer. A beat presented on the flush cycle is dropped, and a pending output beat is discarded even if m_ready=1.
- Reset mid-operation: buffered beats are lost and outputs return to their reset values immediately. The first legal input transfer is at the first rising edge after rstn deasserts.
- Protocol: the producer must hold s_valid/s_data until the transfer completes. The slice's behaviour does not depend on that assumption.

Test Plan:
- Reset then idle: rstn low 3 cycles, release -> m_valid=0, s_ready=1, count=0, m_data=0; no change over 10 idle cycles.
- Streaming, m_ready=1: send 0x0001..0x0010, one per cycle -> each value on m_data one cycle after acceptance; s_ready stays 1; count stays 1; 16 beats out in order.
- Backpressure fill: m_ready=0, send 0xAAAA then 0xBBBB -> count 1 then 2; s_ready=0 after the second edge; m_data=0xAAAA held; 0xCCCC on s_data not accepted.
- Drain from FULL:
  - From the previous state, m_ready=1 for 3 cycles -> m_data sequence 0xAAAA, 0xBBBB.
  - s_ready rises after the first drain edge, and 0xCCCC is accepted when it does.
  - Final order out is AAAA, BBBB, CCCC.
- Simultaneous flush: count=2, flush=1 with s_valid=1 (s_data=0x1234) and m_ready=1 -> next cycle count=0, m_valid=0, s_ready=1; 0x1234 is never output.
- Async reset mid-stream: assert rstn low between edges while count=2 -> m_valid=0, s_ready=1, count=0 immediately without a clock edge; after release, the first beat 0x5555 appears on m_data one cycle after acceptance.
